mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit between the MEM pipeline stage and the word-organised data memory. It accepts one byte/half/word load or store per request and drives the memory's MemWrite/MemRead/address/write-data port. It handles the memory's one-cycle registered read latency, extracts and extends sub-word loads, and builds sub-word stores by read-modify-write. It stalls the pipeline until each access completes and flags misaligned accesses without touching memory.

## Interface
- MEM_DEPTH_LOG2, 8, log2 of memory depth in 32-bit words; word index = req_addr_i[MEM_DEPTH_LOG2+1:2]
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present; held stable by pipeline while stall_o=1
- req_write_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- stall_o  out  1  pipeline must hold
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  load result; 0 for stores/errors/idle
- misalign_o  out  1  with rsp_valid_o: access rejected
- mem_write_o  out  1  memory write strobe
- mem_read_o  out  1  memory read strobe
- mem_addr_o  out  32  word index, zero-extended
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_read_o sampled

## Operation
- States: IDLE, READ, RESP, RMW_RD, RMW_WR, WRITE, ERR. Request fields latched on acceptance; all outputs decode from state and latched fields.
- IDLE + req_valid_i: accept. Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 11 → ERR. Load → READ. Word store → WRITE. Byte/half store → RMW_RD.
- READ: mem_read_o=1 → RESP.
- RESP: rsp_valid_o=1, rsp_rdata_o = lane of mem_rdata_i, extended → IDLE.
- RMW_RD: mem_read_o=1 → RMW_WR.
- RMW_WR: mem_write_o=1, mem_wdata_o = mem_rdata_i with selected lane replaced by low byte/half of latched wdata; rsp_valid_o=1 → IDLE.
- WRITE: mem_write_o=1, mem_wdata_o = latched wdata; rsp_valid_o=1 → IDLE.
- ERR: rsp_valid_o=1, misalign_o=1, rsp_rdata_o=0, no memory strobes → IDLE.
- Little-endian lanes: byte n = bits [8n+7:8n] (n = addr[1:0]); half 0 = [15:0], half 1 = [31:16].
- Address bits above MEM_DEPTH_LOG2+1 ignored (aliasing); bits [1:0] never reach memory.
- Completion states (RESP, RMW_WR, WRITE, ERR) ignore req_valid_i; the next request is accepted only in IDLE.

## Timing
- stall_o = (IDLE and req_valid_i) or state in {READ, RMW_RD}; 0 in completion states, so the pipeline advances on the completion edge.
- Latency from acceptance edge to completion cycle: word store/error 1 cycle; load and sub-word store 2 cycles.
- mem_read_o/mem_write_o high for exactly one cycle per access; at most one memory write per request.
- Reset: rst_i high forces IDLE at the next edge; while rst_i is high, stall_o, rsp_valid_o, misalign_o, mem_write_o, mem_read_o are forced 0, and rsp_rdata_o, mem_addr_o, mem_wdata_o are 0. Reset mid-RMW aborts with no write issued; the memory word is unchanged.
- Outside active states, all outputs are 0.

## Test plan
- Preload word 1 = 0x8899AABB; lw 0x4 → stall_o=1 for 2 cycles, mem_read_o once with mem_addr_o=1, then rsp_valid_o with 0x8899AABB.
- lb 0x7 → 0xFFFFFF88; lbu 0x7 → 0x00000088; lh 0x6 → 0xFFFF8899; lhu 0x4 → 0x0000AABB.
- sb 0x5, wdata 0x12345677 → read then write at index 1, word becomes 0x889977BB; sh 0x6, wdata 0x0000CAFE → 0xCAFE77BB.
- sw 0x8, wdata 0xDEADBEEF → single mem_write_o at index 2, rsp_valid_o 1 cycle after acceptance, no mem_read_o.
- lw 0x6, sh 0x3, size 11 → rsp_valid_o+misalign_o 1 cycle after acceptance, rsp_rdata_o=0, no strobes; lw 0x404 → returns word 1 (alias).
- rst_i high during RMW_RD of sb 0x4 → next cycle IDLE, no mem_write_o, word 1 unchanged, stall_o=0; back-to-back lw requests each complete in order with no missed/duplicated rsp.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MEM stage and a word-organised
// data memory with a one-cycle registered read port.
//
// One byte/half/word load or store is handled per request. Loads read the word
// and extract/extend the addressed lane. Sub-word stores read-modify-write the
// word. Word stores write directly. Misaligned or illegal-size requests complete
// with misalign_o and never touch memory. The pipeline is stalled until the
// completion cycle.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               request from the pipeline (held while stall_o=1)
//   stall_o             pipeline must hold
//   rsp_valid_o         one-cycle completion pulse
//   rsp_rdata_o         load result (0 otherwise)
//   misalign_o          with rsp_valid_o: request rejected
//   mem_write_o/_read_o memory strobes
//   mem_addr_o          word index, zero-extended
//   mem_wdata_o         memory write data
//   mem_rdata_i         memory read data, valid the cycle after mem_read_o
module mem_access_unit #(
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        misalign_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE, READ, RESP, RMW_RD, RMW_WR, WRITE, ERR
    } state_t;

    state_t                    state;
    logic [1:0]                reqSize;
    logic                      reqUnsigned;
    logic [1:0]                reqOff;
    logic [MEM_DEPTH_LOG2-1:0] reqIdx;
    logic [31:0]               reqWdata;

    // Upper address bits alias onto the memory; they are deliberately dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^req_addr_i[31:MEM_DEPTH_LOG2+2];

    logic misaligned;
    assign misaligned = (req_size_i == 2'b11)
                     || (req_size_i == 2'b01 && req_addr_i[0])
                     || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            reqSize     <= '0;
            reqUnsigned <= 1'b0;
            reqOff      <= '0;
            reqIdx      <= '0;
            reqWdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        reqSize     <= req_size_i;
                        reqUnsigned <= req_unsigned_i;
                        reqOff      <= req_addr_i[1:0];
                        reqIdx      <= req_addr_i[MEM_DEPTH_LOG2+1:2];
                        reqWdata    <= req_wdata_i;
                        if (misaligned)                 state <= ERR;
                        else if (!req_write_i)          state <= READ;
                        else if (req_size_i == 2'b10)   state <= WRITE;
                        else                            state <= RMW_RD;
                    end
                end
                READ:    state <= RESP;
                RMW_RD:  state <= RMW_WR;
                // Completion states return to IDLE regardless of req_valid_i.
                RESP, RMW_WR, WRITE, ERR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;
    logic [31:0] mergeData;

    always_comb begin
        loadByte = mem_rdata_i[{reqOff, 3'b000} +: 8];
        loadHalf = reqOff[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (reqSize)
            2'b00:   loadData = {{24{~reqUnsigned & loadByte[7]}}, loadByte};
            2'b01:   loadData = {{16{~reqUnsigned & loadHalf[15]}}, loadHalf};
            default: loadData = mem_rdata_i;
        endcase
        mergeData = mem_rdata_i;
        if (reqSize == 2'b00) mergeData[{reqOff, 3'b000} +: 8] = reqWdata[7:0];
        else                  mergeData[{reqOff[1], 4'b0000} +: 16] = reqWdata[15:0];
    end

    logic [31:0] wordAddr;
    assign wordAddr = {{(32-MEM_DEPTH_LOG2){1'b0}}, reqIdx};

    // Outputs decode from state; everything is held at 0 while in reset.
    always_comb begin
        stall_o     = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        misalign_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            case (state)
                IDLE: stall_o = req_valid_i;
                READ, RMW_RD: begin
                    stall_o    = 1'b1;
                    mem_read_o = 1'b1;
                    mem_addr_o = wordAddr;
                end
                RESP: begin
                    rsp_valid_o = 1'b1;
                    rsp_rdata_o = loadData;
                end
                RMW_WR: begin
                    rsp_valid_o = 1'b1;
                    mem_write_o = 1'b1;
                    mem_addr_o  = wordAddr;
                    mem_wdata_o = mergeData;
                end
                WRITE: begin
                    rsp_valid_o = 1'b1;
                    mem_write_o = 1'b1;
                    mem_addr_o  = wordAddr;
                    mem_wdata_o = reqWdata;
                end
                ERR: begin
                    rsp_valid_o = 1'b1;
                    misalign_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqUnsigned = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic        stall, rspValid, misalign, memWrite, memRead;
    logic [31:0] rspRdata, memAddr, memWdata;
    logic [31:0] memRdata = '0;

    int total = 0;
    int bad = 0;

    mem_access_unit #(.MEM_DEPTH_LOG2(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_write_i(reqWrite), .req_size_i(reqSize),
        .req_unsigned_i(reqUnsigned), .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
        .stall_o(stall), .rsp_valid_o(rspValid), .rsp_rdata_o(rspRdata),
        .misalign_o(misalign), .mem_write_o(memWrite), .mem_read_o(memRead),
        .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle registered read.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (memRead)  memRdata <= mem[memAddr[7:0]];
        if (memWrite) mem[memAddr[7:0]] <= memWdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expMis;
        int          expLat;
        int          expRd;
        int          expWr;
        logic [31:0] expAddr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } rsp_t;

    rsp_t sbq[$];

    // Scoreboard: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rspValid) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sbq.pop_front();
                check("rsp_rdata", rspRdata, e.rdata);
                check("rsp_misalign", {31'd0, misalign}, {31'd0, e.mis});
            end
        end else begin
            check("idle_rdata_zero", rspRdata, 32'd0);
            check("idle_misalign_zero", {31'd0, misalign}, 32'd0);
        end
    end

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input logic expMis,
                                input int expLat, input int expRd, input int expWr,
                                input logic [31:0] expAddr);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.expRdata = expRdata; v.expMis = expMis; v.expLat = expLat;
        v.expRd = expRd; v.expWr = expWr; v.expAddr = expAddr;
        return v;
    endfunction

    // Drive one request right after a rising edge and follow it to completion.
    // The request stays asserted afterwards so the next call runs back-to-back.
    task automatic run(input vec_t v, input int id);
        int k, stalls, reads, writes;
        bit seen;
        rsp_t e;
        @(posedge clk); #1;
        reqValid = 1'b1; reqWrite = v.wr; reqSize = v.size; reqUnsigned = v.uns;
        reqAddr = v.addr; reqWdata = v.wdata;
        e.rdata = v.expRdata; e.mis = v.expMis;
        sbq.push_back(e);
        stalls = 0; reads = 0; writes = 0; seen = 0; k = 0;
        while (!seen && k < 8) begin
            @(negedge clk);
            if (stall) stalls++;
            if (memRead) begin
                reads++;
                check($sformatf("v%0d_rd_addr", id), memAddr, v.expAddr);
            end
            if (memWrite) begin
                writes++;
                check($sformatf("v%0d_wr_addr", id), memAddr, v.expAddr);
            end
            if (rspValid) seen = 1;
            else k++;
        end
        check($sformatf("v%0d_latency", id), k, v.expLat);
        check($sformatf("v%0d_stalls", id), stalls, v.expLat);
        check($sformatf("v%0d_reads", id), reads, v.expRd);
        check($sformatf("v%0d_writes", id), writes, v.expWr);
    endtask

    vec_t vecs[$];

    initial begin
        //            wr  size  uns addr          wdata          expRdata       mis lat rd wr idx
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0004, 32'h8899_AABB, 32'h0,          0, 1, 0, 1, 32'd1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0004, 32'h0,          32'h8899_AABB, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0007, 32'h0,          32'hFFFF_FF88, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0007, 32'h0,          32'h0000_0088, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0006, 32'h0,          32'hFFFF_8899, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0004, 32'h0,          32'h0000_AABB, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0005, 32'h1234_5677, 32'h0,          0, 2, 1, 1, 32'd1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0004, 32'h0,          32'h8899_77BB, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0006, 32'h0000_CAFE, 32'h0,          0, 2, 1, 1, 32'd1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0004, 32'h0,          32'hCAFE_77BB, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0004, 32'h0,          32'hFFFF_FFBB, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0006, 32'h0,          32'h0000_00FE, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0004, 32'h0,          32'h0000_77BB, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0006, 32'h0,          32'hFFFF_CAFE, 0, 2, 1, 0, 32'd1));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,          0, 1, 0, 1, 32'd2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 0, 2, 1, 0, 32'd2));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0008, 32'h0000_00AB, 32'h0,          0, 2, 1, 1, 32'd2));
        vecs.push_back(mk(1, 2'b00, 0, 32'h0000_000B, 32'hFFFF_FF01, 32'h0,          0, 2, 1, 1, 32'd2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0008, 32'h0,          32'h01AD_BEAB, 0, 2, 1, 0, 32'd2));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0006, 32'h0,          32'h0,          1, 1, 0, 0, 32'd0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0003, 32'h1234_5678, 32'h0,          1, 1, 0, 0, 32'd0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h0000_0004, 32'h0,          32'h0,          1, 1, 0, 0, 32'd0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0404, 32'h0,          32'hCAFE_77BB, 0, 2, 1, 0, 32'd1));

        // Reset with a request pending: all outputs must stay at 0.
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqAddr = 32'h4; reqWdata = 32'h1;
        repeat (2) begin
            @(negedge clk);
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
            check("rst_strobes", {30'd0, memWrite, memRead}, 32'd0);
            check("rst_mem_addr", memAddr, 32'd0);
            check("rst_mem_wdata", memWdata, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; reqValid = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_strobes", {30'd0, memWrite, memRead}, 32'd0);

        foreach (vecs[i]) run(vecs[i], i);
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(negedge clk);
        check("post_burst_stall", {31'd0, stall}, 32'd0);

        // Reset during the read half of a byte read-modify-write.
        @(posedge clk); #1;
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddr = 32'h4; reqWdata = 32'h55;
        @(negedge clk);
        check("abort_accept_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        check("abort_rmw_rd_read", {31'd0, memRead}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rst_stall", {31'd0, stall}, 32'd0);
        check("abort_rst_read", {31'd0, memRead}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; reqValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_write", {31'd0, memWrite}, 32'd0);
            check("abort_stall", {31'd0, stall}, 32'd0);
        end
        check("abort_word_unchanged", mem[1], 32'hCAFE_77BB);
        run(mk(0, 2'b10, 0, 32'h4, 32'h0, 32'hCAFE_77BB, 0, 2, 1, 0, 32'd1), 99);
        @(posedge clk); #1;
        reqValid = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung bench.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
